pair_match_checker: RTL

PAIR_MATCH_CHECKER -- requirements
Module: pair_match_checker

---
 rtl/pair_match_checker.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/pair_match_checker.sv
// pair_match_checker
//   Rule engine for a 36-tile memory/concentration game. A board of 1-bit tile
//   values is latched on load; the player reveals two tiles per attempt. Equal
//   tiles become permanently matched, unequal tiles stay face-up for
//   HOLD_CYCLES cycles and are then hidden again.
//
// Optional feature macro: MOVE_COUNT_EN
//   defined   -> 'moves' counts completed pair attempts, saturating at 255
//   undefined -> no move counter is built, 'moves' is tied to 0
//
// Parameters
//   HOLD_CYCLES  cycles a mismatched pair stays visible before being hidden
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous reset, active low
//   load       in   pulse: latch board, clear progress, start a new game
//   board      in   [35:0] tile values, bit k = tile k
//   sel_valid  in   one-cycle tile selection strobe
//   sel_idx    in   [5:0] selected tile index (0..35 valid)
//   shown      out  [35:0] tiles face-up (matched or pending)
//   matched    out  [35:0] tiles permanently matched
//   match_p    out  one-cycle pulse, pair matched
//   miss_p     out  one-cycle pulse, pair mismatched
//   moves      out  [7:0] completed pair attempts
//   done       out  high while every tile is matched
//
// All outputs come straight from flops.

module pair_match_checker #(
  parameter int unsigned HOLD_CYCLES = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [35:0] board,
  input  logic        sel_valid,
  input  logic [5:0]  sel_idx,
  output logic [35:0] shown,
  output logic [35:0] matched,
  output logic        match_p,
  output logic        miss_p,
  output logic [7:0]  moves,
  output logic        done
);

  localparam int unsigned NT = 36;
  // Counter only has to hold HOLD_CYCLES-1.
  localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_SECOND,
    S_CMP,
    S_HOLD,
    S_WIN
  } state_e;

  state_e          state_q;
  logic [NT-1:0]   board_q;
  logic [NT-1:0]   shown_q;
  logic [NT-1:0]   matched_q;
  logic [5:0]      a_q;
  logic [5:0]      b_q;
  logic [CW-1:0]   hold_cnt_q;
  logic            match_p_q;
  logic            miss_p_q;
  logic            done_q;

  // ---------------------------------------------------------------------------
  // Selection qualification
  // ---------------------------------------------------------------------------
  // Widened copy so a 6-bit index can never fall outside the vector; the
  // range check still rejects 36..63.
  logic [63:0]   matched_ext;
  logic          idx_in_range;
  logic          idx_ok;
  logic          sel_first_ok;
  logic          sel_second_ok;
  logic [NT-1:0] bit_sel;
  logic [NT-1:0] bit_a;
  logic [NT-1:0] bit_b;
  logic [NT-1:0] matched_nxt;
  logic          tiles_eq;

  assign matched_ext   = {28'd0, matched_q};
  assign idx_in_range  = (sel_idx <= 6'd35);
  assign idx_ok        = idx_in_range && !matched_ext[sel_idx];
  assign sel_first_ok  = sel_valid && idx_ok;
  // Re-selecting the first tile of the pair is not a second pick.
  assign sel_second_ok = sel_valid && idx_ok && (sel_idx != a_q);

  assign bit_sel     = 36'd1 << sel_idx;
  assign bit_a       = 36'd1 << a_q;
  assign bit_b       = 36'd1 << b_q;
  assign matched_nxt = matched_q | bit_a | bit_b;
  // Only the latched copy is ever compared; the live board is ignored.
  assign tiles_eq    = (board_q[a_q] == board_q[b_q]);

  // ---------------------------------------------------------------------------
  // Game FSM and its registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      board_q    <= '0;
      shown_q    <= '0;
      matched_q  <= '0;
      a_q        <= '0;
      b_q        <= '0;
      hold_cnt_q <= '0;
      match_p_q  <= 1'b0;
      miss_p_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      match_p_q <= 1'b0;
      miss_p_q  <= 1'b0;
      if (load) begin
        // load outranks everything, including a same-cycle selection.
        board_q    <= board;
        shown_q    <= '0;
        matched_q  <= '0;
        a_q        <= '0;
        b_q        <= '0;
        hold_cnt_q <= '0;
        done_q     <= 1'b0;
        state_q    <= S_FIRST;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            // waits for load; selections are ignored
          end
          S_FIRST: begin
            if (sel_first_ok) begin
              a_q     <= sel_idx;
              shown_q <= shown_q | bit_sel;
              state_q <= S_SECOND;
            end
          end
          S_SECOND: begin
            if (sel_second_ok) begin
              b_q     <= sel_idx;
              shown_q <= shown_q | bit_sel;
              state_q <= S_CMP;
            end
          end
          S_CMP: begin
            if (tiles_eq) begin
              matched_q <= matched_nxt;
              match_p_q <= 1'b1;
              if (&matched_nxt) begin
                done_q  <= 1'b1;
                state_q <= S_WIN;
              end else begin
                state_q <= S_FIRST;
              end
            end else begin
              miss_p_q   <= 1'b1;
              hold_cnt_q <= HOLD_LOAD;
              state_q    <= S_HOLD;
            end
          end
          S_HOLD: begin
            // Pair stays visible for HOLD_CYCLES cycles in total.
            if (hold_cnt_q == '0) begin
              shown_q <= shown_q & ~(bit_a | bit_b);
              state_q <= S_FIRST;
            end else begin
              hold_cnt_q <= hold_cnt_q - CW'(1);
            end
          end
          S_WIN: begin
            // terminal until load or reset
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Move counter
  // ---------------------------------------------------------------------------
`ifdef MOVE_COUNT_EN
  logic [7:0] moves_q;
  logic [7:0] moves_d;
  logic       attempt_done;

  // Every CMP cycle finishes one attempt, match or miss.
  assign attempt_done = (state_q == S_CMP);

  always_comb begin
    moves_d = moves_q;
    if (load) begin
      moves_d = 8'd0;
    end else if (attempt_done && (moves_q != 8'hFF)) begin
      moves_d = moves_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      moves_q <= 8'd0;
    end else begin
      moves_q <= moves_d;
    end
  end

  assign moves = moves_q;
`else
  assign moves = 8'd0;
`endif

  assign shown   = shown_q;
  assign matched = matched_q;
  assign match_p = match_p_q;
  assign miss_p  = miss_p_q;
  assign done    = done_q;

endmodule
